counter_sequencer: RTL

Controller that sequences the board's three demo counters (up, Johnson, ripple-down) so they share one LED bank. It replaces driving counters from a divided clock: a prescaler on the single system clock produces one-cycle tick enables, and an FSM decides which counter receives them. The FSM also issues a clear pulse to each counter as it is entered and drives the LED mux select. It sits between the top-level switches and the counter instances.

---
 rtl/counter_pkg.sv | 44 ++++
 rtl/counter_sequencer_tick_gen.sv | 42 ++++
 rtl/counter_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the counter sequencer: mode encoding that
// doubles as the LED mux select, mode indices and default timing.
package counter_pkg;

   // Encoding chosen so the state register can drive sel directly.
   typedef enum logic [1:0] {
      S_UP   = 2'd0,
      S_JOHN = 2'd1,
      S_DOWN = 2'd2,
      S_IDLE = 2'd3
   } state_e;

   localparam int MODE_UP   = 0;
   localparam int MODE_JOHN = 1;
   localparam int MODE_DOWN = 2;

   localparam int DEF_TICK_DIV = 25000000;
   localparam int DEF_DWELL    = 16;

   // IDLE always moves to UP; the counting modes rotate UP -> JOHN -> DOWN.
   function automatic state_e next_mode(input state_e s);
      state_e n;
      case (s)
         S_UP:    n = S_JOHN;
         S_JOHN:  n = S_DOWN;
         S_DOWN:  n = S_UP;
         default: n = S_UP;
      endcase
      return n;
   endfunction

   function automatic logic [2:0] mode_onehot(input state_e s);
      logic [2:0] oh;
      oh = 3'b000;
      case (s)
         S_UP:    oh[MODE_UP]   = 1'b1;
         S_JOHN:  oh[MODE_JOHN] = 1'b1;
         S_DOWN:  oh[MODE_DOWN] = 1'b1;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/counter_sequencer_tick_gen.sv
// Prescaler on the system clock. tick_fire is the combinational "this edge
// wraps" strobe; the sequencer registers it together with its own outputs.
module tick_gen
   import counter_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int CW       = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic hold,
   output logic tick_fire
);

   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // hold freezes the count in place so a release resumes mid-period.
   always_comb begin
      cnt_d     = cnt_q;
      tick_fire = 1'b0;
      if (!hold) begin
         if (cnt_q == LAST) begin
            cnt_d     = '0;
            tick_fire = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// Routes prescaler ticks to one of three demo counters, rotating modes on
// dwell expiry (run=1) or on a synchronized step edge; all outputs registered.
module counter_sequencer
   import counter_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int DWELL    = DEF_DWELL,
   parameter int CW       = 25,
   parameter int DW       = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic          hold,
   input  logic          step,
   output logic          tick,
   output logic [2:0]    cnt_en,
   output logic [2:0]    cnt_clr,
   output logic [1:0]    sel,
   output logic [DW-1:0] dwell_left
);

   localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL);
   localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

   logic tick_fire;

   tick_gen #(
      .TICK_DIV (TICK_DIV),
      .CW       (CW)
   ) u_tick_gen (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .tick_fire (tick_fire)
   );

   state_e        state_q, state_d;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          sync3_q, sync3_d;
   logic          tick_q, tick_d;
   logic [2:0]    cnt_en_q, cnt_en_d;
   logic [2:0]    cnt_clr_q, cnt_clr_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic          step_evt;
   logic          advance;

   // sync1/sync2 resynchronize the raw switch; sync3 holds the previous value
   // so a held-high switch yields a single event.
   always_comb begin
      sync1_d = step;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
   end

   assign step_evt = sync2_q & ~sync3_q;

   // A step while auto-running is ignored; in IDLE either source starts UP.
   always_comb begin
      advance = 1'b0;
      if (state_q == S_IDLE) begin
         advance = run | step_evt;
      end else if (run) begin
         advance = tick_fire & (dwell_q == DWELL_ONE);
      end else begin
         advance = step_evt;
      end
   end

   always_comb begin
      state_d   = state_q;
      tick_d    = tick_fire;
      cnt_en_d  = 3'b000;
      cnt_clr_d = 3'b000;
      dwell_d   = dwell_q;

      if (advance) begin
         state_d = next_mode(state_q);
      end

      // The expiring tick still belongs to the old mode; the new mode only
      // sees its clear on this edge.
      if (tick_fire) begin
         cnt_en_d = mode_onehot(state_q);
      end
      if (advance) begin
         cnt_clr_d = mode_onehot(state_d);
      end

      if (advance) begin
         dwell_d = DWELL_LOAD;
      end else if ((state_q != S_IDLE) && run && tick_fire && (dwell_q > DWELL_ONE)) begin
         dwell_d = dwell_q - DWELL_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         sync3_q   <= 1'b0;
         tick_q    <= 1'b0;
         cnt_en_q  <= 3'b000;
         cnt_clr_q <= 3'b000;
         dwell_q   <= DWELL_LOAD;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         sync3_q   <= sync3_d;
         tick_q    <= tick_d;
         cnt_en_q  <= cnt_en_d;
         cnt_clr_q <= cnt_clr_d;
         dwell_q   <= dwell_d;
      end
   end

   assign tick       = tick_q;
   assign cnt_en     = cnt_en_q;
   assign cnt_clr    = cnt_clr_q;
   assign sel        = state_q;
   assign dwell_left = dwell_q;

endmodule
